// File: rtl/iob_cpu_bus_arbiter_if.sv
// Bus bundle for iob_cpu_bus_arbiter.
// Carries both requester ports (instruction bus = requester 0, data bus =
// requester 1, packed side by side) and the single IOb slave port.
//   master : view used by the arbiter (it masters the memory port)
//   slave  : view used by the environment (requesters + memory)
// Signals:
//   m_valid_i/m_addr_i/m_wdata_i/m_wstrb_i  requester requests (packed x2)
//   m_ready_o/m_rvalid_o/m_rdata_o          per-requester responses
//   s_valid_o/s_addr_o/s_wdata_o/s_wstrb_o  slave request
//   s_ready_i/s_rvalid_i/s_rdata_i          slave response
//   grant_o, stray_rvalid_o                 status
interface iob_cpu_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]            m_valid_i;
    logic [2*ADDR_W-1:0]   m_addr_i;
    logic [2*DATA_W-1:0]   m_wdata_i;
    logic [2*DATA_W/8-1:0] m_wstrb_i;
    logic [1:0]            m_ready_o;
    logic [1:0]            m_rvalid_o;
    logic [2*DATA_W-1:0]   m_rdata_o;
    logic                  s_valid_o;
    logic [ADDR_W-1:0]     s_addr_o;
    logic [DATA_W-1:0]     s_wdata_o;
    logic [DATA_W/8-1:0]   s_wstrb_o;
    logic                  s_ready_i;
    logic                  s_rvalid_i;
    logic [DATA_W-1:0]     s_rdata_i;
    logic                  grant_o;
    logic                  stray_rvalid_o;

    modport master (
        input  m_valid_i, m_addr_i, m_wdata_i, m_wstrb_i,
        input  s_ready_i, s_rvalid_i, s_rdata_i,
        output m_ready_o, m_rvalid_o, m_rdata_o,
        output s_valid_o, s_addr_o, s_wdata_o, s_wstrb_o,
        output grant_o, stray_rvalid_o
    );

    modport slave (
        output m_valid_i, m_addr_i, m_wdata_i, m_wstrb_i,
        output s_ready_i, s_rvalid_i, s_rdata_i,
        input  m_ready_o, m_rvalid_o, m_rdata_o,
        input  s_valid_o, s_addr_o, s_wdata_o, s_wstrb_o,
        input  grant_o, stray_rvalid_o
    );
endinterface

// File: rtl/iob_cpu_bus_arbiter.sv
// Two-requester round-robin arbiter merging the CPU instruction bus
// (requester 0) and data bus (requester 1) onto one IOb memory port.
// At most one transaction in flight; read data is routed back only to the
// requester that issued the read.
// Ports:
//   clk_i     clock
//   arst_n_i  asynchronous reset, active low
//   cke_i     clock enable; registers hold while low
//   bus       iob_cpu_bus_arbiter_if.master (requester + slave signals)
module iob_cpu_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  cke_i,
    iob_cpu_bus_arbiter_if.master bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, LOCK, RD_WAIT} state_t;

    state_t state;
    logic   last_grant;
    logic   owner;
    logic   lock_idx;
    logic   stray_q;

    logic              sel;
    logic              s_valid;
    logic              is_read;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic [STRB_W-1:0] wstrb_sel;
    logic [1:0]        ready_bits;
    logic [1:0]        rvalid_bits;
    logic [2*DATA_W-1:0] rdata_bits;

    always_comb begin
        // LOCK freezes the mux on the stalled requester; otherwise a tie goes
        // to the requester that was not served last.
        if (state == LOCK)
            sel = lock_idx;
        else if (&bus.m_valid_i)
            sel = ~last_grant;
        else
            sel = bus.m_valid_i[1];

        addr_sel  = sel ? bus.m_addr_i[ADDR_W +: ADDR_W]  : bus.m_addr_i[0 +: ADDR_W];
        wdata_sel = sel ? bus.m_wdata_i[DATA_W +: DATA_W] : bus.m_wdata_i[0 +: DATA_W];
        wstrb_sel = sel ? bus.m_wstrb_i[STRB_W +: STRB_W] : bus.m_wstrb_i[0 +: STRB_W];
        is_read   = (wstrb_sel == '0);

        // Handshake outputs are forced low while reset is asserted.
        s_valid = arst_n_i && (state != RD_WAIT) && bus.m_valid_i[sel];

        ready_bits = '0;
        if (arst_n_i && (state != RD_WAIT))
            ready_bits[sel] = bus.s_ready_i;

        rvalid_bits = '0;
        if (arst_n_i && (state == RD_WAIT) && bus.s_rvalid_i)
            rvalid_bits[owner] = 1'b1;

        rdata_bits = '0;
        if (rvalid_bits[0])
            rdata_bits[0 +: DATA_W] = bus.s_rdata_i;
        if (rvalid_bits[1])
            rdata_bits[DATA_W +: DATA_W] = bus.s_rdata_i;
    end

    assign bus.s_valid_o      = s_valid;
    assign bus.s_addr_o       = addr_sel;
    assign bus.s_wdata_o      = wdata_sel;
    assign bus.s_wstrb_o      = wstrb_sel;
    assign bus.m_ready_o      = ready_bits;
    assign bus.m_rvalid_o     = rvalid_bits;
    assign bus.m_rdata_o      = rdata_bits;
    assign bus.grant_o        = last_grant;
    assign bus.stray_rvalid_o = stray_q;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            lock_idx   <= 1'b0;
            stray_q    <= 1'b0;
        end else if (cke_i) begin
            stray_q <= bus.s_rvalid_i && (state != RD_WAIT);
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        if (bus.s_ready_i) begin
                            last_grant <= sel;
                            if (is_read) begin
                                owner <= sel;
                                state <= RD_WAIT;
                            end
                        end else begin
                            lock_idx <= sel;
                            state    <= LOCK;
                        end
                    end
                end
                LOCK: begin
                    // Requester withdrew its request: abandon without a transfer.
                    if (!bus.m_valid_i[lock_idx]) begin
                        state <= IDLE;
                    end else if (bus.s_ready_i) begin
                        last_grant <= lock_idx;
                        if (is_read) begin
                            owner <= lock_idx;
                            state <= RD_WAIT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                RD_WAIT: begin
                    if (bus.s_rvalid_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iob_cpu_bus_arbiter.sv
module tb_iob_cpu_bus_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic arst_n;
    logic cke;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        idx;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    iob_cpu_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    iob_cpu_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i    (clk),
        .arst_n_i (arst_n),
        .cke_i    (cke),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic idx, input logic [31:0] data);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        sb.push_back(e);
    endtask

    // Read-response monitor: every rvalid must match the oldest expected read.
    always @(negedge clk) begin
        if (bus.m_rvalid_o !== 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", {62'd0, bus.m_rvalid_o}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_rvalid", {62'd0, bus.m_rvalid_o}, e.idx ? 64'd2 : 64'd1);
                chk("sb_rdata", bus.m_rdata_o, e.idx ? {e.data, 32'd0} : {32'd0, e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    logic        exp_last;
    logic        exp_win;
    logic [31:0] rd_data;

    initial begin
        arst_n = 1'b0;
        cke    = 1'b1;
        bus.m_valid_i  = '0;
        bus.m_addr_i   = '0;
        bus.m_wdata_i  = '0;
        bus.m_wstrb_i  = '0;
        bus.s_ready_i  = 1'b0;
        bus.s_rvalid_i = 1'b0;
        bus.s_rdata_i  = '0;
        #12;
        chk("rst_grant", {63'd0, bus.grant_o}, 64'd1);
        chk("rst_stray", {63'd0, bus.stray_rvalid_o}, 64'd0);
        chk("rst_ready", {62'd0, bus.m_ready_o}, 64'd0);
        chk("rst_rvalid", {62'd0, bus.m_rvalid_o}, 64'd0);
        chk("rst_svalid", {63'd0, bus.s_valid_o}, 64'd0);
        step();
        arst_n = 1'b1;
        step();

        // 1: uncontended read from requester 0
        bus.m_valid_i = 2'b01;
        bus.m_addr_i  = {32'h0, 32'h100};
        bus.s_ready_i = 1'b1;
        #1;
        chk("t1_svalid", {63'd0, bus.s_valid_o}, 64'd1);
        chk("t1_saddr", {32'd0, bus.s_addr_o}, 64'h100);
        chk("t1_ready", {62'd0, bus.m_ready_o}, 64'd1);
        step();
        bus.m_valid_i = 2'b00;
        bus.s_ready_i = 1'b0;
        #1;
        chk("t1_grant", {63'd0, bus.grant_o}, 64'd0);
        chk("t1_rdwait_svalid", {63'd0, bus.s_valid_o}, 64'd0);
        step();
        push(1'b0, 32'hDEADBEEF);
        bus.s_rvalid_i = 1'b1;
        bus.s_rdata_i  = 32'hDEADBEEF;
        #1;
        chk("t1_rvalid", {62'd0, bus.m_rvalid_o}, 64'd1);
        step();
        bus.s_rvalid_i = 1'b0;
        #1;
        chk("t1_no_stray", {63'd0, bus.stray_rvalid_o}, 64'd0);
        exp_last = 1'b0;

        // 2: both requesters reading continuously -> alternating grants
        bus.m_valid_i = 2'b11;
        bus.m_addr_i  = {32'h300, 32'h200};
        for (int i = 0; i < 4; i++) begin
            bus.s_ready_i = 1'b1;
            #1;
            exp_win = ~exp_last;
            chk("t2_saddr", {32'd0, bus.s_addr_o}, exp_win ? 64'h300 : 64'h200);
            chk("t2_ready", {62'd0, bus.m_ready_o}, exp_win ? 64'd2 : 64'd1);
            rd_data = 32'hA000_0000 + 32'(i);
            push(exp_win, rd_data);
            step();
            exp_last = exp_win;
            chk("t2_grant", {63'd0, bus.grant_o}, {63'd0, exp_win});
            bus.s_ready_i  = 1'b0;
            bus.s_rvalid_i = 1'b1;
            bus.s_rdata_i  = rd_data;
            #1;
            chk("t2_rdwait_ready", {62'd0, bus.m_ready_o}, 64'd0);
            step();
            bus.s_rvalid_i = 1'b0;
        end
        bus.m_valid_i = 2'b00;

        // 3: requester 1 write stalled 3 cycles, requester 0 joins mid-stall
        bus.m_addr_i  = {32'h400, 32'h500};
        bus.m_wdata_i = {32'h12345678, 32'h0};
        bus.m_wstrb_i = {4'hF, 4'h0};
        bus.m_valid_i = 2'b10;
        #1;
        chk("t3_svalid", {63'd0, bus.s_valid_o}, 64'd1);
        chk("t3_saddr_c1", {32'd0, bus.s_addr_o}, 64'h400);
        step();
        bus.m_valid_i = 2'b11;
        #1;
        chk("t3_saddr_c2", {32'd0, bus.s_addr_o}, 64'h400);
        chk("t3_swdata_c2", {32'd0, bus.s_wdata_o}, 64'h12345678);
        chk("t3_ready_c2", {62'd0, bus.m_ready_o}, 64'd0);
        step();
        chk("t3_saddr_c3", {32'd0, bus.s_addr_o}, 64'h400);
        step();
        bus.s_ready_i = 1'b1;
        #1;
        chk("t3_saddr_acc", {32'd0, bus.s_addr_o}, 64'h400);
        chk("t3_swstrb_acc", {60'd0, bus.s_wstrb_o}, 64'hF);
        chk("t3_ready_acc", {62'd0, bus.m_ready_o}, 64'd2);
        step();
        bus.m_valid_i = 2'b01;
        #1;
        chk("t3_rd_saddr", {32'd0, bus.s_addr_o}, 64'h500);
        chk("t3_rd_ready", {62'd0, bus.m_ready_o}, 64'd1);
        push(1'b0, 32'hCAFEF00D);
        step();
        bus.m_valid_i  = 2'b00;
        bus.s_ready_i  = 1'b0;
        bus.s_rvalid_i = 1'b1;
        bus.s_rdata_i  = 32'hCAFEF00D;
        step();
        bus.s_rvalid_i = 1'b0;
        bus.m_wstrb_i  = '0;
        step();

        // 4: stray rvalid in IDLE
        bus.s_rvalid_i = 1'b1;
        bus.s_rdata_i  = 32'h5555AAAA;
        #1;
        chk("t4_rvalid", {62'd0, bus.m_rvalid_o}, 64'd0);
        step();
        bus.s_rvalid_i = 1'b0;
        #1;
        chk("t4_stray_hi", {63'd0, bus.stray_rvalid_o}, 64'd1);
        step();
        chk("t4_stray_lo", {63'd0, bus.stray_rvalid_o}, 64'd0);

        // 5: reset while a read is outstanding
        bus.m_addr_i  = {32'h0, 32'h600};
        bus.m_valid_i = 2'b01;
        bus.s_ready_i = 1'b1;
        step();
        bus.m_valid_i = 2'b00;
        bus.s_ready_i = 1'b0;
        arst_n = 1'b0;
        #1;
        chk("t5_rst_grant", {63'd0, bus.grant_o}, 64'd1);
        chk("t5_rst_svalid", {63'd0, bus.s_valid_o}, 64'd0);
        step();
        arst_n = 1'b1;
        step();
        bus.s_rvalid_i = 1'b1;
        bus.s_rdata_i  = 32'h00000BAD;
        #1;
        chk("t5_dropped_rvalid", {62'd0, bus.m_rvalid_o}, 64'd0);
        step();
        bus.s_rvalid_i = 1'b0;
        #1;
        chk("t5_stray", {63'd0, bus.stray_rvalid_o}, 64'd1);
        bus.m_addr_i  = {32'h680, 32'h640};
        bus.m_valid_i = 2'b11;
        bus.s_ready_i = 1'b1;
        #1;
        chk("t5_tie_ready", {62'd0, bus.m_ready_o}, 64'd1);
        chk("t5_tie_saddr", {32'd0, bus.s_addr_o}, 64'h640);
        push(1'b0, 32'h11111111);
        step();
        bus.m_valid_i  = 2'b00;
        bus.s_ready_i  = 1'b0;
        bus.s_rvalid_i = 1'b1;
        bus.s_rdata_i  = 32'h11111111;
        step();
        bus.s_rvalid_i = 1'b0;
        step();

        // 6: clock enable low while a request is locked
        bus.m_addr_i  = {32'h700, 32'h740};
        bus.m_valid_i = 2'b10;
        step();
        cke = 1'b0;
        bus.m_valid_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            bus.s_ready_i = (i == 1);
            #1;
            if (i != 1) begin
                chk("t6_hold_svalid", {63'd0, bus.s_valid_o}, 64'd1);
                chk("t6_hold_saddr", {32'd0, bus.s_addr_o}, 64'h700);
            end
            step();
        end
        cke = 1'b1;
        bus.s_ready_i = 1'b1;
        #1;
        chk("t6_ready", {62'd0, bus.m_ready_o}, 64'd2);
        chk("t6_saddr", {32'd0, bus.s_addr_o}, 64'h700);
        push(1'b1, 32'h77777777);
        step();
        chk("t6_grant", {63'd0, bus.grant_o}, 64'd1);
        bus.m_valid_i  = 2'b00;
        bus.s_ready_i  = 1'b0;
        bus.s_rvalid_i = 1'b1;
        bus.s_rdata_i  = 32'h77777777;
        step();
        bus.s_rvalid_i = 1'b0;
        step();
        step();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
